// File: rtl/cla_add_sequencer.sv
// Round-robin arbitrated 64-bit adder that streams both 32-bit halves of an
// operation through one carry-lookahead adder on consecutive cycles.
module cla_add_sequencer #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [64*NREQ-1:0]   i_req_a,
  input  logic [64*NREQ-1:0]   i_req_b,
  input  logic [NREQ-1:0]      i_req_cin,
  input  logic [TAGW*NREQ-1:0] i_req_tag,
  output logic [NREQ-1:0]      o_req_ready,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [63:0]          o_res_sum,
  output logic                 o_res_cout,
  output logic                 o_res_ovf,
  output logic [TAGW-1:0]      o_res_tag,
  output logic                 o_busy
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [PTRW-1:0] r_rr_ptr;
  logic [63:0]     r_a;
  logic [63:0]     r_b;
  logic            r_cin;
  logic [TAGW-1:0] r_tag;
  logic [31:0]     r_sum_lo;
  logic            r_carry_lo;
  logic [63:0]     r_res_sum;
  logic            r_res_cout;
  logic            r_res_ovf;
  logic [TAGW-1:0] r_res_tag;
  logic            r_res_valid;
  logic            r_busy;

  logic [NREQ-1:0] w_grant;
  logic            w_grant_any;
  logic [PTRW-1:0] w_grant_idx;
  logic [PTRW:0]   w_idx;
  logic [PTRW-1:0] w_ptr_nxt;
  logic            w_hs;
  logic [63:0]     w_cap_a;
  logic [63:0]     w_cap_b;
  logic            w_cap_cin;
  logic [TAGW-1:0] w_cap_tag;
  logic [31:0]     w_add_a;
  logic [31:0]     w_add_b;
  logic            w_add_ci;
  logic [31:0]     w_add_sum;
  logic            w_add_co;

  // 32-bit adder: 4-bit lookahead groups with a lookahead chain across groups
  function automatic logic [32:0] cla32(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < 8; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = ci;
    for (int j = 0; j < 8; j++) gc[j+1] = gg[j] | (gp[j] & gc[j]);
    for (int j = 0; j < 8; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                 (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    return {gc[8], p ^ c};
  endfunction

  // Rotating-priority search: first valid requester at or after rr_ptr
  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTRW+1)'(k);
      if (w_idx >= (PTRW+1)'(NREQ)) w_idx = w_idx - (PTRW+1)'(NREQ);
      if (!w_grant_any && i_req_valid[w_idx[PTRW-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_idx[PTRW-1:0];
      end
    end
    if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
  end

  assign o_req_ready = (r_state == S_IDLE && !i_rst) ? w_grant : '0;
  assign w_hs        = (r_state == S_IDLE) && w_grant_any;
  assign w_ptr_nxt   = (w_grant_idx == PTRW'(NREQ - 1)) ? '0 : w_grant_idx + PTRW'(1);

  // Operand selection for the granted requester
  always_comb begin
    w_cap_a   = '0;
    w_cap_b   = '0;
    w_cap_cin = 1'b0;
    w_cap_tag = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_grant[i]) begin
        w_cap_a   = i_req_a[64*i +: 64];
        w_cap_b   = i_req_b[64*i +: 64];
        w_cap_cin = i_req_cin[i];
        w_cap_tag = i_req_tag[TAGW*i +: TAGW];
      end
    end
  end

  // Shared adder: low half in LO, high half with registered carry in HI
  always_comb begin
    w_add_a  = r_a[31:0];
    w_add_b  = r_b[31:0];
    w_add_ci = r_cin;
    if (r_state == S_HI) begin
      w_add_a  = r_a[63:32];
      w_add_b  = r_b[63:32];
      w_add_ci = r_carry_lo;
    end
    {w_add_co, w_add_sum} = cla32(w_add_a, w_add_b, w_add_ci);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_any) w_state_nxt = S_LO;
      S_LO:    w_state_nxt = S_HI;
      S_HI:    w_state_nxt = S_DONE;
      S_DONE:  if (i_res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Operand capture, half-sum pipeline, result and status registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_tag       <= '0;
      r_sum_lo    <= '0;
      r_carry_lo  <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_res_tag   <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != S_IDLE);
      r_res_valid <= (w_state_nxt == S_DONE);
      if (w_hs) begin
        r_rr_ptr <= w_ptr_nxt;
        r_a      <= w_cap_a;
        r_b      <= w_cap_b;
        r_cin    <= w_cap_cin;
        r_tag    <= w_cap_tag;
      end
      if (r_state == S_LO) begin
        r_sum_lo   <= w_add_sum;
        r_carry_lo <= w_add_co;
      end
      if (r_state == S_HI) begin
        r_res_sum  <= {w_add_sum, r_sum_lo};
        r_res_cout <= w_add_co;
        r_res_ovf  <= (r_a[63] == r_b[63]) && (w_add_sum[31] != r_a[63]);
        r_res_tag  <= r_tag;
      end
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_sum   = r_res_sum;
  assign o_res_cout  = r_res_cout;
  assign o_res_ovf   = r_res_ovf;
  assign o_res_tag   = r_res_tag;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Testbench for cla_add_sequencer: directed scenarios plus a randomized
// regression against a 65-bit arithmetic / rotating-priority reference model.
module tb_cla_add_sequencer;

  localparam int NREQ = 4;
  localparam int TAGW = 3;
  localparam int NOPS = 10000;
  localparam int MAXCYC = 70000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      valid;
  logic [64*NREQ-1:0]   req_a;
  logic [64*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_cin;
  logic [TAGW*NREQ-1:0] req_tag;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [63:0]          res_sum;
  logic                 res_cout;
  logic                 res_ovf;
  logic [TAGW-1:0]      res_tag;
  logic                 busy;

  logic [63:0]     op_a   [NREQ];
  logic [63:0]     op_b   [NREQ];
  logic            op_cin [NREQ];
  logic [TAGW-1:0] op_tag [NREQ];

  int n_cmp  = 0;
  int n_fail = 0;
  int m_ptr  = 0;

  cla_add_sequencer #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_a(req_a), .i_req_b(req_b),
    .i_req_cin(req_cin), .i_req_tag(req_tag), .o_req_ready(req_ready),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_sum(res_sum),
    .o_res_cout(res_cout), .o_res_ovf(res_ovf), .o_res_tag(res_tag), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Pack per-requester operands onto the flat request buses
  always_comb begin
    req_a   = '0;
    req_b   = '0;
    req_cin = '0;
    req_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[64*i +: 64]     = op_a[i];
      req_b[64*i +: 64]     = op_b[i];
      req_cin[i]            = op_cin[i];
      req_tag[TAGW*i +: TAGW] = op_tag[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // {ovf, cout, sum} from plain 65-bit arithmetic
  function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic ci);
    logic [64:0] s;
    logic        ovf;
    s   = {1'b0, a} + {1'b0, b} + 65'(ci);
    ovf = (a[63] == b[63]) && (s[63] != a[63]);
    return {ovf, s};
  endfunction

  function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int idx);
    logic [NREQ-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic chk_result(input string name, input logic [65:0] e, input logic [TAGW-1:0] t);
    chk({name, ".valid"}, 64'(res_valid), 64'(1'b1));
    chk({name, ".sum"},   res_sum, e[63:0]);
    chk({name, ".cout"},  64'(res_cout), 64'(e[64]));
    chk({name, ".ovf"},   64'(res_ovf), 64'(e[65]));
    chk({name, ".tag"},   64'(res_tag), 64'(t));
  endtask

  // One isolated operation from requester r with zero back-pressure
  task automatic single_op(input string name, input int r, input logic [63:0] a,
                           input logic [63:0] b, input logic ci, input logic [TAGW-1:0] t);
    logic [65:0] e;
    op_a[r] = a; op_b[r] = b; op_cin[r] = ci; op_tag[r] = t;
    valid = '0;
    valid[r] = 1'b1;
    res_ready = 1'b1;
    e = ref_add(a, b, ci);
    #1;
    chk({name, ".grant"}, 64'(req_ready), 64'(onehot(pick(m_ptr, valid))));
    m_ptr = (r + 1) % NREQ;
    step();
    valid = '0;
    chk({name, ".lo_busy"}, 64'(busy), 64'(1'b1));
    chk({name, ".lo_valid"}, 64'(res_valid), 64'(1'b0));
    step();
    chk({name, ".hi_valid"}, 64'(res_valid), 64'(1'b0));
    step();
    chk_result(name, e, t);
    step();
    chk({name, ".idle_valid"}, 64'(res_valid), 64'(1'b0));
    chk({name, ".idle_busy"}, 64'(busy), 64'(1'b0));
  endtask

  initial begin
    logic [65:0]     e;
    logic [NREQ-1:0] pend;
    logic [TAGW-1:0] exp_tag;
    logic [TAGW-1:0] tag_ctr;
    int              cnt;
    int              gnt;
    int              done_ops;
    int              cyc;

    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_cin[i] = 1'b0; op_tag[i] = '0;
    end
    rst = 1'b1; valid = '0; res_ready = 1'b0;

    // Reset: no grant while rst is high, then all outputs at reset values
    step();
    valid = '1;
    step();
    chk("rst.ready", 64'(req_ready), 64'(0));
    valid = '0;
    rst = 1'b0;
    #1;
    chk("rst.valid", 64'(res_valid), 64'(0));
    chk("rst.sum",   res_sum, 64'(0));
    chk("rst.cout",  64'(res_cout), 64'(0));
    chk("rst.ovf",   64'(res_ovf), 64'(0));
    chk("rst.tag",   64'(res_tag), 64'(0));
    chk("rst.busy",  64'(busy), 64'(0));

    // Directed arithmetic corners
    single_op("half_carry", 2, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 3'd5);
    single_op("wrap_cout", 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 3'd6);
    single_op("signed_ovf", 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 3'd1);

    // Back-pressure: result held for 10 cycles, no grant while in DONE
    op_a[2] = {$urandom, $urandom}; op_b[2] = {$urandom, $urandom};
    op_cin[2] = 1'($urandom); op_tag[2] = 3'd2;
    op_a[0] = 64'd7; op_b[0] = 64'd9; op_cin[0] = 1'b0; op_tag[0] = 3'd0;
    e = ref_add(op_a[2], op_b[2], op_cin[2]);
    valid = 4'b0100;
    res_ready = 1'b0;
    #1;
    chk("bp.grant", 64'(req_ready), 64'(onehot(pick(m_ptr, valid))));
    m_ptr = 3;
    step();
    valid = 4'b0001;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      chk_result("bp.hold", e, 3'd2);
      chk("bp.ready", 64'(req_ready), 64'(0));
      chk("bp.busy", 64'(busy), 64'(1));
      step();
    end
    res_ready = 1'b1;
    #1;
    chk_result("bp.release", e, 3'd2);
    step();
    chk("bp.idle_valid", 64'(res_valid), 64'(0));
    chk("bp.idle_busy", 64'(busy), 64'(0));
    chk("bp.next_grant", 64'(req_ready), 64'(onehot(pick(m_ptr, valid))));
    valid = '0;
    step();
    chk("withdraw.busy", 64'(busy), 64'(0));
    chk("withdraw.valid", 64'(res_valid), 64'(0));

    // Reset in HI discards the operation and rewinds the pointer
    op_a[3] = 64'd100; op_b[3] = 64'd200; op_cin[3] = 1'b0; op_tag[3] = 3'd3;
    valid = 4'b1000;
    #1;
    chk("rstmid.grant", 64'(req_ready), 64'(onehot(pick(m_ptr, valid))));
    step();
    valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ptr = 0;
    chk("rstmid.valid", 64'(res_valid), 64'(0));
    chk("rstmid.busy", 64'(busy), 64'(0));
    valid = '1;
    #1;
    chk("rstmid.ptr", 64'(req_ready), 64'(4'b0001));
    valid = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rstmid.no_result", 64'(res_valid), 64'(0));
    end

    // Arbitration: all requesting, grants rotate 0,1,2,3,0 every 4 cycles
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = {$urandom, $urandom}; op_b[i] = {$urandom, $urandom};
      op_cin[i] = 1'($urandom); op_tag[i] = TAGW'(i + 4);
    end
    valid = '1;
    res_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      gnt = pick(m_ptr, valid);
      chk("arb.order", 64'(gnt), 64'(g % NREQ));
      chk("arb.grant", 64'(req_ready), 64'(onehot(gnt)));
      e = ref_add(op_a[gnt], op_b[gnt], op_cin[gnt]);
      m_ptr = (gnt + 1) % NREQ;
      step();
      chk("arb.lo_ready", 64'(req_ready), 64'(0));
      step();
      chk("arb.hi_ready", 64'(req_ready), 64'(0));
      step();
      chk_result("arb.result", e, op_tag[gnt]);
      step();
    end
    valid = '0;
    step();

    // Randomized regression against the reference model
    pend = '0; cnt = 0; done_ops = 0; cyc = 0; tag_ctr = '0; exp_tag = '0; e = '0;
    while (done_ops < NOPS && cyc < MAXCYC) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(1, 0) != 0) begin
          op_a[i]   = ($urandom_range(7, 0) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
          op_b[i]   = ($urandom_range(7, 0) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
          op_cin[i] = 1'($urandom);
          op_tag[i] = tag_ctr;
          tag_ctr   = tag_ctr + TAGW'(1);
          pend[i]   = 1'b1;
        end
      end
      valid = pend;
      res_ready = ($urandom_range(7, 0) != 0);
      #1;
      gnt = (cnt == 0) ? pick(m_ptr, pend) : -1;
      chk("rnd.ready", 64'(req_ready), 64'(onehot(gnt)));
      chk("rnd.busy", 64'(busy), 64'(cnt != 0));
      chk("rnd.valid", 64'(res_valid), 64'(cnt == 3));
      if (cnt == 3) chk_result("rnd", e, exp_tag);
      if (cnt == 3) begin
        if (res_ready) begin
          cnt = 0;
          done_ops++;
        end
      end else if (cnt > 0) begin
        cnt++;
      end else if (gnt >= 0) begin
        cnt = 1;
        e = ref_add(op_a[gnt], op_b[gnt], op_cin[gnt]);
        exp_tag = op_tag[gnt];
        pend[gnt] = 1'b0;
        m_ptr = (gnt + 1) % NREQ;
      end
      step();
      cyc++;
    end
    chk("rnd.completed_ops", 64'(done_ops), 64'(NOPS));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_add_sequencer.md
# cla_add_sequencer

Arbitrated, multi-cycle 64-bit integer/mantissa add unit for the Tomasulo execution cluster. Up to NREQ reservation-station requesters share one 32-bit carry-lookahead adder instance; the block selects a requester round-robin, runs the low and high 32-bit halves through the single adder on consecutive cycles with the carry registered between them, and presents the 64-bit result with its tag on a valid/ready port toward the common data bus.

## Interface
- NREQ, 4, number of requesters (2..8)
- TAGW, 3, width of the reservation-station tag carried with each operation
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  requester i has an operation pending
- req_a  in  64*NREQ  operand A of requester i at bits [64*i+63:64*i]
- req_b  in  64*NREQ  operand B, same packing
- req_cin  in  NREQ  carry-in of requester i
- req_tag  in  TAGW*NREQ  tag of requester i, packed as above
- req_ready  out  NREQ  one-hot grant; operands of requester i captured when req_valid[i] & req_ready[i]
- res_valid  out  1  result available
- res_ready  in  1  CDB accepts result
- res_sum  out  64  A + B + cin, modulo 2^64
- res_cout  out  1  carry out of bit 63
- res_ovf  out  1  signed overflow: A[63]==B[63] and res_sum[63]!=A[63]
- res_tag  out  TAGW  tag of the granted requester
- busy  out  1  high in every state except IDLE

## Operation
- Single internal 32-bit CLA (A, B, carry-in → 32-bit sum, carry-out); its inputs are muxed by state; no second adder instance.
- States: IDLE, LO, HI, DONE.
- IDLE: req_ready is one-hot on the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ; all-zero if no req_valid. On handshake, latch A, B, cin, tag; rr_ptr ← (i+1) mod NREQ; go to LO.
- LO: adder inputs A[31:0], B[31:0], latched cin; register sum_lo and carry_lo; go to HI.
- HI: adder inputs A[63:32], B[63:32], carry_lo; register sum_hi, cout, ovf; go to DONE.
- DONE: res_valid=1, res_* stable; on res_ready=1 go to IDLE. No new grant is issued in DONE.
- req_ready is zero in LO, HI, DONE; requesters must keep req_valid and operands stable until granted.
- Deasserting req_valid before grant withdraws the request; no state change.
- rr_ptr changes only on a grant handshake.

## Timing
- Reset values: state IDLE, rr_ptr 0, req_ready all-zero during reset, res_valid 0, res_sum 0, res_cout 0, res_ovf 0, res_tag 0, busy 0.
- Handshake in cycle T (IDLE) → LO in T+1, HI in T+2, res_valid=1 from T+3.
- Zero back-pressure: next grant possible at T+4; maximum throughput one operation per 4 cycles.
- res_ready held low: stay in DONE indefinitely, outputs unchanged.
- res_ready high while res_valid low: ignored.
- Multiple req_valid in the same cycle: exactly one grant, by rotating priority; a continuously requesting input waits at most NREQ-1 other grants.
- rr_ptr wraps NREQ-1 → 0.
- rst in LO, HI or DONE: the operation is discarded without a result; next cycle state is IDLE with all reset values; a request granted in the same cycle as rst is not captured.
- res_* registered outputs only; req_ready is combinational from state, rr_ptr and req_valid.

## Test plan
- Single add, requester 2: A=0x0000_0000_FFFF_FFFF, B=1, cin=0, tag=5 → res_valid at T+3, res_sum=0x0000_0001_0000_0000, cout=0, ovf=0, res_tag=5 (carry through the half boundary).
- Carry/overflow: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → sum 0, cout=1, ovf=0; A=0x7FFF_FFFF_FFFF_FFFF, B=1 → sum 0x8000_0000_0000_0000, ovf=1, cout=0.
- Arbitration: all four req_valid held high, res_ready=1 → grants in order 0,1,2,3,0, one every 4 cycles, tags match.
- Back-pressure: res_ready=0 for 10 cycles after res_valid → res_* stable, req_ready all-zero, busy=1; res_ready=1 → IDLE next cycle, new grant the cycle after.
- Reset mid-operation: assert rst in HI → next cycle state IDLE, res_valid=0, busy=0, rr_ptr=0; the discarded operation produces no result.
- Random regression: 10k random operands/cin/requesters → every res_sum, cout and ovf matches the 65-bit reference sum, each tag returned exactly once.
